// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, constants and tap offset tables for the CONV sequencer
package conv_pkg;

    localparam int DEF_IMG_W   = 64;
    localparam int DEF_ADDR_W  = 2 * $clog2(DEF_IMG_W);
    localparam int DEF_MAC_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        WR0,
        PRD,
        PWAIT,
        WR1,
        DONE
    } state_t;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    // Two's-complement 2-bit row/col offsets of 3x3 tap k: dr = k/3-1, dc = k%3-1.
    function automatic logic [1:0] tap_dr(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: tap_dr = 2'b11;
            4'd3, 4'd4, 4'd5: tap_dr = 2'b00;
            default:          tap_dr = 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] tap_dc(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: tap_dc = 2'b11;
            4'd1, 4'd4, 4'd7: tap_dc = 2'b00;
            default:          tap_dc = 2'b01;
        endcase
    endfunction

endpackage

// File: rtl/conv_tap_gen.sv
// rtl/conv_tap_gen.sv - combinational (row, col, tap) to image address and pad flag
module conv_tap_gen
    import conv_pkg::*;
#(
    parameter int LW = 6
) (
    input  logic [LW-1:0]   row,
    input  logic [LW-1:0]   col,
    input  logic [3:0]      kidx,
    output logic [2*LW-1:0] iaddr,
    output logic            pad
);

    logic [1:0]    dr;
    logic [1:0]    dc;
    logic [LW+1:0] r;
    logic [LW+1:0] c;

    // Two guard bits: the top one flags -1, the next one flags IMG_W.
    always_comb begin
        dr    = tap_dr(kidx);
        dc    = tap_dc(kidx);
        r     = {2'b00, row} + {{LW{dr[1]}}, dr};
        c     = {2'b00, col} + {{LW{dc[1]}}, dc};
        pad   = r[LW+1] | r[LW] | c[LW+1] | c[LW];
        iaddr = pad ? '0 : {r[LW-1:0], c[LW-1:0]};
    end

endmodule

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - frame sequencer: conv+ReLU into layer0, 2x2 max-pool into layer1
module conv_sched
    import conv_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int MAC_LAT = DEF_MAC_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    output logic [ADDR_W-1:0] iaddr,
    output logic              pad,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [3:0]        kidx,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    output logic              pool_clr,
    output logic              pool_en,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [2:0]        csel
);

    localparam int LW = ADDR_W / 2;
    localparam int HW = LW - 1;
    localparam int BW = ADDR_W - 2;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [BW-1:0]     blk_q, blk_d;
    logic [3:0]        tap_q, tap_d;

    logic              busy_q, busy_d, pad_q, pad_d, mac_clr_q, mac_clr_d, mac_en_q, mac_en_d;
    logic              crd_q, crd_d, pool_clr_q, pool_clr_d, pool_en_q, pool_en_d, cwr_q, cwr_d;
    logic [ADDR_W-1:0] iaddr_q, iaddr_d, caddr_rd_q, caddr_rd_d, caddr_wr_q, caddr_wr_d;
    logic [3:0]        kidx_q, kidx_d;
    logic [2:0]        csel_q, csel_d;

    logic [LW-1:0]     tg_row, tg_col;
    logic [3:0]        tg_k;
    logic [ADDR_W-1:0] tg_addr;
    logic              tg_pad;

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        blk_d   = blk_q;
        tap_d   = tap_q;
        case (state_q)
            IDLE: if (ready) begin
                state_d = FETCH;
                pix_d   = '0;
                tap_d   = '0;
            end
            FETCH: begin
                tap_d = tap_q + 4'd1;
                if (tap_q == 4'd8) begin
                    state_d = WAIT;
                    tap_d   = '0;
                end
            end
            WAIT: begin
                tap_d = tap_q + 4'd1;
                if (tap_q == 4'(MAC_LAT - 1)) begin
                    state_d = WR0;
                    tap_d   = '0;
                end
            end
            WR0: begin
                pix_d   = pix_q + 1'b1;
                tap_d   = '0;
                state_d = (&pix_q) ? PRD : FETCH;
                if (&pix_q) blk_d = '0;
            end
            PRD: begin
                tap_d = tap_q + 4'd1;
                if (tap_q == 4'd3) begin
                    state_d = PWAIT;
                    tap_d   = '0;
                end
            end
            PWAIT: state_d = WR1;
            WR1: begin
                blk_d   = blk_q + 1'b1;
                tap_d   = '0;
                state_d = (&blk_q) ? DONE : PRD;
            end
            default: state_d = IDLE;
        endcase
    end

    // One address generator serves both phases: pool reads are taps 0,1,3,4 around (2pr+1, 2pc+1).
    always_comb begin
        tg_row = pix_d[ADDR_W-1 -: LW];
        tg_col = pix_d[LW-1:0];
        tg_k   = tap_d;
        if (state_d == PRD) begin
            tg_row = {blk_d[BW-1 -: HW], 1'b1};
            tg_col = {blk_d[HW-1:0], 1'b1};
            tg_k   = tap_d[1] ? (4'd3 + {3'b000, tap_d[0]}) : {3'b000, tap_d[0]};
        end
    end

    conv_tap_gen #(.LW(LW)) u_tap_gen (
        .row   (tg_row),
        .col   (tg_col),
        .kidx  (tg_k),
        .iaddr (tg_addr),
        .pad   (tg_pad)
    );

    always_comb begin
        busy_d     = (state_d != IDLE);
        iaddr_d    = '0;
        pad_d      = 1'b0;
        mac_clr_d  = 1'b0;
        mac_en_d   = 1'b0;
        kidx_d     = '0;
        crd_d      = 1'b0;
        caddr_rd_d = '0;
        pool_en_d  = (state_q == PRD);
        pool_clr_d = (state_q == PRD) && (tap_q == 4'd0);
        cwr_d      = 1'b0;
        caddr_wr_d = '0;
        csel_d     = CSEL_NONE;
        case (state_d)
            FETCH: begin
                mac_en_d  = 1'b1;
                mac_clr_d = (tap_d == 4'd0);
                kidx_d    = tap_d;
                iaddr_d   = tg_addr;
                pad_d     = tg_pad;
            end
            WR0: begin
                cwr_d      = 1'b1;
                csel_d     = CSEL_L0;
                caddr_wr_d = pix_d;
            end
            PRD: begin
                crd_d      = 1'b1;
                csel_d     = CSEL_L0;
                caddr_rd_d = tg_addr;
            end
            WR1: begin
                cwr_d      = 1'b1;
                csel_d     = CSEL_L1;
                caddr_wr_d = {2'b00, blk_d};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pix_q      <= '0;
            blk_q      <= '0;
            tap_q      <= '0;
            busy_q     <= 1'b0;
            iaddr_q    <= '0;
            pad_q      <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            kidx_q     <= '0;
            crd_q      <= 1'b0;
            caddr_rd_q <= '0;
            pool_clr_q <= 1'b0;
            pool_en_q  <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_wr_q <= '0;
            csel_q     <= CSEL_NONE;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            blk_q      <= blk_d;
            tap_q      <= tap_d;
            busy_q     <= busy_d;
            iaddr_q    <= iaddr_d;
            pad_q      <= pad_d;
            mac_clr_q  <= mac_clr_d;
            mac_en_q   <= mac_en_d;
            kidx_q     <= kidx_d;
            crd_q      <= crd_d;
            caddr_rd_q <= caddr_rd_d;
            pool_clr_q <= pool_clr_d;
            pool_en_q  <= pool_en_d;
            cwr_q      <= cwr_d;
            caddr_wr_q <= caddr_wr_d;
            csel_q     <= csel_d;
        end
    end

    assign busy     = busy_q;
    assign iaddr    = iaddr_q;
    assign pad      = pad_q;
    assign mac_clr  = mac_clr_q;
    assign mac_en   = mac_en_q;
    assign kidx     = kidx_q;
    assign crd      = crd_q;
    assign caddr_rd = caddr_rd_q;
    assign pool_clr = pool_clr_q;
    assign pool_en  = pool_en_q;
    assign cwr      = cwr_q;
    assign caddr_wr = caddr_wr_q;
    assign csel     = csel_q;

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - self-checking bench for conv_sched against a cycle-index reference model
module tb_conv_sched;

    localparam int P     = 12;
    localparam int NPIX  = 4096;
    localparam int NBLK  = 1024;
    localparam int TOTAL = NPIX * P + NBLK * 6 + 1;
    localparam int LP    = (NPIX - 1) * P;
    localparam int Q     = NPIX * P;
    localparam int B     = Q + (NBLK - 1) * 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ready = 1'b0;
    logic        busy, pad, mac_clr, mac_en, crd, pool_clr, pool_en, cwr;
    logic [11:0] iaddr, caddr_rd, caddr_wr;
    logic [3:0]  kidx;
    logic [2:0]  csel;

    int n_cmp = 0;
    int n_fail = 0;
    int mn = 0;
    bit rand_ready = 1'b0;

    conv_sched #(.IMG_W(64), .ADDR_W(12), .MAC_LAT(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .busy     (busy),
        .iaddr    (iaddr),
        .pad      (pad),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .kidx     (kidx),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .pool_clr (pool_clr),
        .pool_en  (pool_en),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .csel     (csel)
    );

    always #5 clk = ~clk;

    // Expected outputs n cycles after the start edge (n==0 means idle), derived from the frame schedule.
    function automatic logic [50:0] model_out(input int n);
        logic b = 0, pd = 0, mclr = 0, men = 0, rd = 0, pclr = 0, pen = 0, wr = 0;
        logic [11:0] ia = 0, ra = 0, wa = 0;
        logic [3:0] k = 0;
        logic [2:0] cs = 0;
        int p, ph, m, r, c, blk;
        if (n > 0) begin
            b = 1;
            if (n <= NPIX * P) begin
                p  = (n - 1) / P;
                ph = (n - 1) % P;
                if (ph < 9) begin
                    men  = 1;
                    mclr = (ph == 0);
                    k    = 4'(ph);
                    r    = p / 64 + ph / 3 - 1;
                    c    = p % 64 + ph % 3 - 1;
                    pd   = (r < 0 || r > 63 || c < 0 || c > 63);
                    ia   = pd ? 12'd0 : 12'(r * 64 + c);
                end else if (ph == P - 1) begin
                    wr = 1; cs = 3'b001; wa = 12'(p);
                end
            end else begin
                m = n - 1 - NPIX * P;
                if (m < NBLK * 6) begin
                    blk  = m / 6;
                    ph   = m % 6;
                    pen  = (ph >= 1 && ph <= 4);
                    pclr = (ph == 1);
                    if (ph < 4) begin
                        rd = 1; cs = 3'b001;
                        ra = 12'((2 * (blk / 32) + ph / 2) * 64 + 2 * (blk % 32) + ph % 2);
                    end else if (ph == 5) begin
                        wr = 1; cs = 3'b011; wa = 12'(blk);
                    end
                end
            end
        end
        return {b, ia, pd, mclr, men, k, rd, ra, pclr, pen, wr, wa, cs};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic directed(input int n);
        case (n)
            1, 2, 3, 4, 7:   chk("p0_pad", 64'(pad), 64'd1);
            5:               chk("p0_k4", 64'({pad, iaddr}), 64'd0);
            6:               chk("p0_k5", 64'({pad, iaddr}), 64'd1);
            8:               chk("p0_k7", 64'({pad, iaddr}), 64'd64);
            9:               chk("p0_k8", 64'({pad, iaddr}), 64'd65);
            12:              chk("p0_wr0", 64'({cwr, csel, caddr_wr}), 64'({1'b1, 3'b001, 12'd0}));
            LP + 1:          chk("plast_k0", 64'({pad, iaddr}), 64'd4030);
            LP + 5:          chk("plast_k4", 64'({pad, iaddr}), 64'd4095);
            LP + 3, LP + 6, LP + 7, LP + 8, LP + 9: chk("plast_pad", 64'(pad), 64'd1);
            LP + 12:         chk("plast_wr0", 64'({cwr, csel, caddr_wr}), 64'({1'b1, 3'b001, 12'd4095}));
            Q + 1:           chk("b0_rd0", 64'({crd, caddr_rd}), 64'({1'b1, 12'd0}));
            Q + 2:           chk("b0_rd1", 64'({crd, caddr_rd, pool_en, pool_clr}), 64'({1'b1, 12'd1, 2'b11}));
            Q + 3:           chk("b0_rd2", 64'({crd, caddr_rd}), 64'({1'b1, 12'd64}));
            Q + 4:           chk("b0_rd3", 64'({crd, caddr_rd}), 64'({1'b1, 12'd65}));
            Q + 6:           chk("b0_wr1", 64'({cwr, csel, caddr_wr}), 64'({1'b1, 3'b011, 12'd0}));
            B + 1:           chk("blast_rd0", 64'(caddr_rd), 64'd4030);
            B + 2:           chk("blast_rd1", 64'(caddr_rd), 64'd4031);
            B + 3:           chk("blast_rd2", 64'(caddr_rd), 64'd4094);
            B + 4:           chk("blast_rd3", 64'(caddr_rd), 64'd4095);
            B + 6:           chk("blast_wr1", 64'({cwr, csel, caddr_wr}), 64'({1'b1, 3'b011, 12'd1023}));
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset)          mn = 0;
        else if (mn == 0)    mn = ready ? 1 : 0;
        else if (mn == TOTAL) mn = 0;
        else                 mn++;
        @(negedge clk);
        chk($sformatf("cycle_n%0d", mn),
            {13'b0, busy, iaddr, pad, mac_clr, mac_en, kidx, crd, caddr_rd,
             pool_clr, pool_en, cwr, caddr_wr, csel},
            {13'b0, model_out(mn)});
        directed(mn);
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int k, target, cnt, gap, guard;
        reset = 1'b0;
        ready = 1'b1;
        repeat (3) step();
        chk("rst_idle", 64'({busy, cwr, crd, csel}), 64'd0);
        reset = 1'b1;
        step();
        chk("start_busy", 64'(busy), 64'd1);

        rand_ready = 1'b1;
        k      = $urandom_range(0, 8);
        target = 100 * P + 1 + k;
        guard  = 0;
        while (mn < target && guard < 2000) begin
            step();
            guard++;
        end
        chk("abort_tap", 64'({mac_en, kidx}), 64'({1'b1, 4'(k)}));
        rand_ready = 1'b0;
        ready = 1'b0;
        reset = 1'b0;
        step();
        chk("abort_zero", 64'({busy, mac_en, pad, cwr, crd, csel, iaddr, kidx}), 64'd0);
        reset = 1'b1;
        repeat (20) begin
            step();
            chk("no_cwr_after_abort", 64'(cwr), 64'd0);
        end

        ready = 1'b1;
        step();
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_pix0", 64'({mac_clr, pad, kidx}), 64'({1'b1, 1'b1, 4'd0}));
        rand_ready = 1'b1;
        cnt = 1;
        while (busy === 1'b1 && cnt < TOTAL + 100) begin
            if (mn >= TOTAL - 4) begin
                rand_ready = 1'b0;
                ready = 1'b1;
            end
            step();
            if (busy === 1'b1) cnt++;
        end
        chk("busy_len", 64'(cnt), 64'(TOTAL));

        gap = 1;
        while (busy === 1'b0 && gap < 10) begin
            step();
            if (busy === 1'b0) gap++;
        end
        chk("frame_gap", 64'(gap), 64'd1);
        chk("frame2_start", 64'({busy, mac_clr, kidx}), 64'({1'b1, 1'b1, 4'd0}));
        repeat (3 * P) step();

        ready = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
